// File: rtl/slider_move_gen.sv
// Slider-puzzle move generator: queues blank-move commands and issues legal
// (from, to) moves to a 2x4 board model with fixed ISSUE/SETTLE timing.
module slider_move_gen #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_dir,
  output logic             cmd_ready,
  output logic [2:0]       from,
  output logic [2:0]       to,
  output logic             move_strobe,
  output logic             reject,
  output logic [2:0]       blank_pos,
  output logic             busy,
  output logic [CNT_W-1:0] move_count,
  output logic [CNT_W-1:0] reject_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  localparam logic [1:0] DirUp   = 2'd0;
  localparam logic [1:0] DirDown = 2'd1;
  localparam logic [1:0] DirLeft = 2'd2;

  typedef enum logic [1:0] {StIdle, StIssue, StSettle} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [2:0]       nbr_q, nbr_d;
  logic [2:0]       blank_q, blank_d;
  logic [2:0]       from_q, from_d;
  logic [2:0]       to_q, to_d;
  logic             strobe_q, strobe_d;
  logic             reject_q, reject_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             push, pop;
  logic             head_legal;
  logic [2:0]       head_nbr;
  logic [1:0]       head_dir;

  assign cmd_ready    = count_q < FullCnt;
  assign push         = cmd_valid && cmd_ready;
  assign head_dir     = mem_q[rd_ptr_q];

  assign from         = from_q;
  assign to           = to_q;
  assign move_strobe  = strobe_q;
  assign reject       = reject_q;
  assign blank_pos    = blank_q;
  assign busy         = (state_q != StIdle);
  assign move_count   = mcnt_q;
  assign reject_count = rcnt_q;

  // Neighbour of the blank in the commanded direction; index = {row, col}.
  always_comb begin
    head_legal = 1'b0;
    head_nbr   = blank_q;
    case (head_dir)
      DirUp: begin
        head_legal = blank_q[2];
        head_nbr   = {1'b0, blank_q[1:0]};
      end
      DirDown: begin
        head_legal = ~blank_q[2];
        head_nbr   = {1'b1, blank_q[1:0]};
      end
      DirLeft: begin
        head_legal = (blank_q[1:0] != 2'd0);
        head_nbr   = {blank_q[2], blank_q[1:0] - 2'd1};
      end
      default: begin
        head_legal = (blank_q[1:0] != 2'd3);
        head_nbr   = {blank_q[2], blank_q[1:0] + 2'd1};
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    nbr_d    = nbr_q;
    blank_d  = blank_q;
    from_d   = blank_q;
    to_d     = blank_q;
    strobe_d = 1'b0;
    reject_d = 1'b0;
    mcnt_d   = mcnt_q;
    rcnt_d   = rcnt_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head_legal) begin
            state_d  = StIssue;
            nbr_d    = head_nbr;
            from_d   = head_nbr;
            to_d     = blank_q;
            strobe_d = 1'b1;
          end else begin
            reject_d = 1'b1;
            if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      StIssue: begin
        state_d = StSettle;
        blank_d = nbr_q;
        from_d  = nbr_q;
        to_d    = nbr_q;
        if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      nbr_q    <= '0;
      blank_q  <= '0;
      from_q   <= '0;
      to_q     <= '0;
      strobe_q <= 1'b0;
      reject_q <= 1'b0;
      mcnt_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      nbr_q    <= nbr_d;
      blank_q  <= blank_d;
      from_q   <= from_d;
      to_q     <= to_d;
      strobe_q <= strobe_d;
      reject_q <= reject_d;
      mcnt_q   <= mcnt_d;
      rcnt_q   <= rcnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_ptr_q] <= cmd_dir;
  end

endmodule

// File: tb/tb_slider_move_gen.sv
// Self-checking bench for slider_move_gen: directed scenarios plus random traffic,
// checked against a transaction-level command/board model.
module tb_slider_move_gen;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_dir = 2'd0;
  logic             cmd_ready;
  logic [2:0]       from, to, blank_pos;
  logic             move_strobe, reject, busy;
  logic [CNT_W-1:0] move_count, reject_count;

  slider_move_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_dir      (cmd_dir),
    .cmd_ready    (cmd_ready),
    .from         (from),
    .to           (to),
    .move_strobe  (move_strobe),
    .reject       (reject),
    .blank_pos    (blank_pos),
    .busy         (busy),
    .move_count   (move_count),
    .reject_count (reject_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit mv;
    int f;
    int t;
  } ev_t;

  ev_t evq[$];
  int  strobes[$];
  int  tiles[8];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  occ = 0;
  int  plan_blank = 0;
  int  m_blank = 0;
  int  m_moves = 0;
  int  m_rejects = 0;
  int  last_strobe = -10;
  logic last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_reset();
    evq.delete();
    strobes.delete();
    occ = 0;
    plan_blank = 0;
    m_blank = 0;
    m_moves = 0;
    m_rejects = 0;
    last_strobe = -10;
    for (int i = 0; i < 8; i++) tiles[i] = i;
  endtask

  // Each accepted command resolves, in order, to either a move or a reject.
  task automatic model_push(input logic [1:0] d);
    ev_t e;
    int p, row, col;
    p = plan_blank;
    row = p / 4;
    col = p % 4;
    e.t = p;
    e.f = p;
    case (d)
      UP:      begin e.mv = (row == 1); e.f = p - 4; end
      DOWN:    begin e.mv = (row == 0); e.f = p + 4; end
      LEFT:    begin e.mv = (col != 0); e.f = p - 1; end
      default: begin e.mv = (col != 3); e.f = p + 1; end
    endcase
    if (e.mv) plan_blank = e.f;
    evq.push_back(e);
    occ++;
  endtask

  task automatic check_board();
    int seen, inv, z;
    seen = 0;
    inv = 0;
    z = 0;
    for (int i = 0; i < 8; i++) begin
      seen |= (1 << tiles[i]);
      if (tiles[i] == 0) z = i;
      for (int j = i + 1; j < 8; j++) if (tiles[i] > tiles[j]) inv++;
    end
    check("board_perm", seen, 255);
    check("board_parity", inv % 2, ((z / 4) + (z % 4)) % 2);
  endtask

  function automatic int board_blank();
    int z;
    z = -1;
    for (int i = 0; i < 8; i++) if (tiles[i] == 0) z = i;
    return z;
  endfunction

  task automatic observe();
    ev_t e;
    int tmp;
    if (reject === 1'b1) begin
      check("reject_expected", evq.size() > 0, 1);
      if (evq.size() > 0) begin
        e = evq.pop_front();
        occ--;
        check("reject_kind", e.mv, 0);
      end
      m_rejects++;
    end
    check("blank_pos", blank_pos, m_blank);
    check("move_count", move_count, sat(m_moves));
    check("reject_count", reject_count, sat(m_rejects));
    if (move_strobe === 1'b1) begin
      check("move_expected", evq.size() > 0, 1);
      if (last_strobe >= 0) check("strobe_gap_min", (cyc - last_strobe) >= 3, 1);
      if (evq.size() > 0) begin
        e = evq.pop_front();
        occ--;
        check("move_kind", e.mv, 1);
        check("move_from", from, e.f);
        check("move_to", to, e.t);
        if (e.mv) m_blank = e.f;
      end
      if (!$isunknown({from, to})) begin
        tmp = tiles[int'(from)];
        tiles[int'(from)] = tiles[int'(to)];
        tiles[int'(to)] = tmp;
      end
      check_board();
      strobes.push_back(cyc);
      last_strobe = cyc;
      m_moves++;
    end else begin
      check("noop_from", from, m_blank);
      check("noop_to", to, m_blank);
    end
    check("board_blank", board_blank(), m_blank);
    check("busy", busy, (last_strobe >= 0) && (cyc - last_strobe <= 1));
    check("cmd_ready", cmd_ready, occ < DEPTH);
  endtask

  task automatic tick(input logic v, input logic [1:0] d, input logic r);
    cmd_valid = v;
    cmd_dir = d;
    reset = r;
    @(negedge clock);
    last_acc = v && (cmd_ready === 1'b1) && !r;
    @(posedge clock);
    #1;
    cyc++;
    if (r) model_reset();
    else if (last_acc) model_push(d);
    observe();
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (evq.size() == 0 && (cyc - last_strobe) > 1) break;
      tick(1'b0, 2'd0, 1'b0);
    end
    check("drain_empty", evq.size(), 0);
  endtask

  int n2;
  int acc_n;
  int ev_seen;
  bit fell;
  int pushed;
  logic [1:0] rd;

  initial begin
    model_reset();
    tick(1'b0, 2'd0, 1'b1);
    tick(1'b0, 2'd0, 1'b1);
    check("rst_from", from, 0);
    check("rst_to", to, 0);
    check("rst_strobe", move_strobe, 0);
    check("rst_reject", reject, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_blank", blank_pos, 0);
    check("rst_mcnt", move_count, 0);
    check("rst_rcnt", reject_count, 0);

    // Single legal move, earliest strobe two cycles after the push cycle.
    tick(1'b0, 2'd0, 1'b0);
    tick(1'b1, DOWN, 1'b0);
    tick(1'b0, 2'd0, 1'b0);
    check("down_strobe", move_strobe, 1);
    check("down_from", from, 4);
    check("down_to", to, 0);
    drain();
    check("down_blank", blank_pos, 4);
    check("down_mcnt", move_count, 1);

    // Illegal command from solved position.
    tick(1'b0, 2'd0, 1'b1);
    tick(1'b1, UP, 1'b0);
    tick(1'b0, 2'd0, 1'b0);
    check("up_reject", reject, 1);
    check("up_strobe", move_strobe, 0);
    tick(1'b0, 2'd0, 1'b0);
    check("up_reject_once", reject, 0);
    drain();
    check("up_rcnt", reject_count, 1);
    check("up_blank", blank_pos, 0);

    // Four rights: three moves three cycles apart, then a reject.
    tick(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, RIGHT, 1'b0);
    drain();
    check("right_moves", strobes.size(), 3);
    if (strobes.size() == 3) begin
      check("right_gap1", strobes[1] - strobes[0], 3);
      check("right_gap2", strobes[2] - strobes[1], 3);
    end
    check("right_blank", blank_pos, 3);
    check("right_mcnt", move_count, 3);
    check("right_rcnt", reject_count, 1);

    // Hold valid until the FIFO fills.
    tick(1'b0, 2'd0, 1'b1);
    acc_n = 0;
    ev_seen = 0;
    fell = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, acc_n[0] ? UP : DOWN, 1'b0);
      if (last_acc) acc_n++;
      if (move_strobe === 1'b1 || reject === 1'b1) ev_seen++;
      if (cmd_ready === 1'b0) begin
        fell = 1;
        break;
      end
    end
    check("full_ready_fell", fell, 1);
    check("full_accepted", acc_n - ev_seen, DEPTH);
    drain();

    // Reset during the ISSUE cycle of the second of three queued moves.
    tick(1'b0, 2'd0, 1'b1);
    tick(1'b1, DOWN, 1'b0);
    tick(1'b1, RIGHT, 1'b0);
    tick(1'b1, UP, 1'b0);
    n2 = (move_strobe === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && n2 < 2; i++) begin
      tick(1'b0, 2'd0, 1'b0);
      if (move_strobe === 1'b1) n2++;
    end
    check("abort_second_seen", n2, 2);
    tick(1'b0, 2'd0, 1'b1);
    check("abort_from", from, 0);
    check("abort_to", to, 0);
    check("abort_strobe", move_strobe, 0);
    check("abort_busy", busy, 0);
    check("abort_blank", blank_pos, 0);
    check("abort_mcnt", move_count, 0);
    check("abort_ready", cmd_ready, 1);
    for (int i = 0; i < 10; i++) tick(1'b0, 2'd0, 1'b0);
    check("abort_no_more_moves", strobes.size(), 0);

    // Random traffic with one mid-stream reset.
    tick(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      rd = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 99) < 60, rd, i == 200);
    end
    drain();

    // Counter saturation with alternating down/up.
    tick(1'b0, 2'd0, 1'b1);
    pushed = 0;
    for (int i = 0; i < 3000 && pushed < CMAX + 3; i++) begin
      tick(1'b1, pushed[0] ? UP : DOWN, 1'b0);
      if (last_acc) pushed++;
    end
    check("sat_pushed", pushed, CMAX + 3);
    drain();
    check("sat_mcnt", move_count, CMAX);
    check("sat_blank", blank_pos, 0);
    check("sat_rcnt", reject_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slider_move_gen.md
SLIDER_MOVE_GEN -- requirements
Module: slider_move_gen

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO depth in entries (power of 2, >= 2).
REQ-002 Parameter: CNT_W, default 8, width of move and reject counters.
REQ-003 Port: clock  input  1  single clock; all state updates on posedge clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 Port: cmd_valid  input  1  direction command offered.
REQ-006 Port: cmd_dir  input  2  blank-move direction: 0 up, 1 down, 2 left, 3 right.
REQ-007 Port: cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-008 Port: from  output  3  source cell index, 0..7, fed to the 2x4 board model.
REQ-009 Port: to  output  3  destination cell index (current blank), fed to the board model.
REQ-010 Port: move_strobe  output  1  high in the cycle a legal move is presented on from/to.
REQ-011 Port: reject  output  1  one-cycle pulse when a dequeued command is illegal.
REQ-012 Port: blank_pos  output  3  tracked blank-cell index.
REQ-013 Port: busy  output  1  high in states ISSUE and SETTLE.
REQ-014 Port: move_count  output  CNT_W  number of legal moves issued, saturating.
REQ-015 Port: reject_count  output  CNT_W  number of illegal commands dropped, saturating.

Function
REQ-016 Board geometry: 2 rows x 4 columns; index bit 2 = row, bits 1:0 = column.
REQ-017 Command FIFO: push when cmd_valid && cmd_ready; cmd_ready = (occupancy < DEPTH); a push and a pop in the same cycle are both performed and occupancy is unchanged.
REQ-018 Commands are dequeued in order, one per move cycle, only in state IDLE with FIFO non-empty.
REQ-019 Legality, with blank at index p: up legal iff p[2]==1 (neighbor p-4); down legal iff p[2]==0 (p+4); left legal iff p[1:0]!=0 (p-1); right legal iff p[1:0]!=3 (p+1).
REQ-020 FSM states: IDLE, ISSUE, SETTLE.
REQ-021 IDLE: from = to = blank_pos and move_strobe = 0; this pair is a no-op for the board model.
REQ-022 IDLE with a legal head command: pop it; next state is ISSUE with the neighbor n latched.
REQ-023 IDLE with an illegal head command: pop it; reject = 1 on the following cycle; reject_count increments; state stays IDLE; blank_pos is unchanged.
REQ-024 ISSUE lasts exactly 1 cycle: from = n, to = blank_pos, move_strobe = 1.
REQ-025 At the end of ISSUE: blank_pos <= n, move_count increments, and the next state is SETTLE.
REQ-026 SETTLE lasts exactly 1 cycle: from = to = new blank_pos, move_strobe = 0; the next state is IDLE.
REQ-027 Minimum spacing between consecutive move_strobe pulses is 3 cycles, which gives the board model one registered-input cycle before the next move.
REQ-028 from, to, move_strobe and reject are registered outputs, with no combinational path from cmd_*.
REQ-029 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-030 A command pushed while the FIFO is empty reaches the FIFO head one cycle after the push; the earliest resulting move_strobe is 2 cycles after the push cycle.

Reset
REQ-031 Reset takes effect on posedge clock while reset is high.
REQ-032 Reset values: FIFO empty, cmd_ready = 1, state IDLE, blank_pos = 0 (solved configuration), from = to = 0, move_strobe = 0, reject = 0, busy = 0, move_count = 0, reject_count = 0.
REQ-033 Reset asserted during ISSUE or SETTLE aborts the move: blank_pos returns to 0 and all queued commands are discarded.
REQ-034 cmd_valid is ignored while reset is high.

Verification
REQ-035 After reset, push down -> move_strobe with from=4, to=0; then blank_pos=4 and move_count=1.
REQ-036 After reset, push up -> no move_strobe; reject pulses once; reject_count=1; blank_pos stays 0.
REQ-037 After reset, push right,right,right,right -> three moves with (from,to) = (1,0), (2,1), (3,2), spaced 3 cycles apart; the fourth command is rejected; blank_pos=3.
REQ-038 Hold cmd_valid high with the FIFO stalled -> exactly DEPTH commands accepted before cmd_ready falls; cmd_ready rises in the cycle after the first pop.
REQ-039 Assert reset in the ISSUE cycle of the second of three queued moves -> all outputs return to reset values next cycle and no further move_strobe occurs.
REQ-040 Drive 2^CNT_W+2 alternating down/up commands -> move_count holds at 2^CNT_W-1; the board model's permutation and parity invariants hold throughout.
